// File: rtl/dm_pkg.sv
// Shared definitions for the DataMover chunk sequencer: command/status field layout,
// FSM encoding and the 72-bit command builder.
package dm_pkg;

  localparam int CMD_W        = 72;
  localparam int CMD_TAG_LSB  = 64;
  localparam int CMD_TAG_W    = 4;
  localparam int CMD_ADDR_LSB = 32;
  localparam int CMD_ADDR_W   = 32;
  localparam int CMD_DRR_BIT  = 31;
  localparam int CMD_EOF_BIT  = 30;
  localparam int CMD_DSA_LSB  = 24;
  localparam int CMD_DSA_W    = 6;
  localparam int CMD_TYPE_BIT = 23;
  localparam int CMD_BTT_LSB  = 0;
  localparam int CMD_BTT_W    = 23;

  localparam int STS_OKAY    = 7;
  localparam int STS_SLVERR  = 6;
  localparam int STS_DECERR  = 5;
  localparam int STS_INTERR  = 4;
  localparam int STS_TAG_LSB = 0;
  localparam int STS_TAG_W   = 4;

  typedef logic [1:0] dm_state_t;
  localparam dm_state_t ST_IDLE  = 2'd0;
  localparam dm_state_t ST_ISSUE = 2'd1;
  localparam dm_state_t ST_DRAIN = 2'd2;
  localparam dm_state_t ST_DONE  = 2'd3;

  function automatic logic [CMD_W-1:0] dm_build_cmd(
    input logic [CMD_TAG_W-1:0]  tag,
    input logic [CMD_ADDR_W-1:0] addr,
    input logic                  eof,
    input logic [CMD_BTT_W-1:0]  btt
  );
    logic [CMD_W-1:0] c;
    c = '0;
    c[CMD_TAG_LSB +: CMD_TAG_W]   = tag;
    c[CMD_ADDR_LSB +: CMD_ADDR_W] = addr;
    c[CMD_DRR_BIT]                = 1'b0;
    c[CMD_EOF_BIT]                = eof;
    c[CMD_DSA_LSB +: CMD_DSA_W]   = '0;
    c[CMD_TYPE_BIT]               = 1'b1;
    c[CMD_BTT_LSB +: CMD_BTT_W]   = btt;
    return c;
  endfunction

  function automatic logic dm_sts_ok(input logic [7:0] sts, input logic [STS_TAG_W-1:0] exp_tag);
    return sts[STS_OKAY] && !sts[STS_SLVERR] && !sts[STS_DECERR] && !sts[STS_INTERR] &&
           (sts[STS_TAG_LSB +: STS_TAG_W] == exp_tag);
  endfunction

endpackage

// File: rtl/dm_cmd_issuer.sv
// One DataMover channel: generates chunk commands under an outstanding-depth limit
// and checks the returning in-order status stream.
module dm_cmd_issuer
  import dm_pkg::*;
#(
  parameter int CHUNK_BYTES     = 1024,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        start,
  input  logic [31:0] base,
  input  logic [31:0] total,
  input  logic [22:0] last_btt,
  input  logic        run,
  input  logic        cnt_en,
  output logic [71:0] cmd_tdata,
  output logic        cmd_tvalid,
  input  logic        cmd_tready,
  input  logic [7:0]  sts_tdata,
  input  logic        sts_tvalid,
  output logic        all_issued,
  output logic        idle,
  output logic        sts_bad,
  output logic [31:0] ok_cnt
);

  logic [31:0] issued, total_q, addr;
  logic [22:0] last_btt_q;
  logic [3:0]  outst, exp_tag;
  logic        hs, dec, last, can_issue, sts_good;

  assign hs        = cmd_tvalid && cmd_tready;
  // A status with nothing outstanding is only legal against a same-cycle handshake.
  assign dec       = sts_tvalid && (outst != 4'd0 || hs);
  assign last      = (issued == total_q - 32'd1);
  assign can_issue = run && !cmd_tvalid && (issued < total_q) &&
                     (outst < 4'(MAX_OUTSTANDING));
  assign sts_good  = dm_sts_ok(sts_tdata, exp_tag);
  assign sts_bad   = sts_tvalid && !sts_good;

  assign all_issued = (issued == total_q);
  assign idle       = !cmd_tvalid && (outst == 4'd0);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      issued     <= '0;
      total_q    <= '0;
      addr       <= '0;
      last_btt_q <= '0;
      outst      <= '0;
      exp_tag    <= '0;
      ok_cnt     <= '0;
      cmd_tvalid <= 1'b0;
      cmd_tdata  <= '0;
    end else if (start) begin
      issued     <= '0;
      total_q    <= total;
      addr       <= base;
      last_btt_q <= last_btt;
      outst      <= '0;
      exp_tag    <= '0;
      ok_cnt     <= '0;
      cmd_tvalid <= 1'b0;
    end else begin
      // tvalid drops for one cycle after each handshake, capping a channel at one command per two cycles.
      if (hs) begin
        cmd_tvalid <= 1'b0;
        issued     <= issued + 32'd1;
        addr       <= addr + 32'(CHUNK_BYTES);
      end else if (can_issue) begin
        cmd_tvalid <= 1'b1;
        cmd_tdata  <= dm_build_cmd(issued[3:0], addr, last,
                                   last ? last_btt_q : 23'(CHUNK_BYTES));
      end
      if (hs && !dec)      outst <= outst + 4'd1;
      else if (!hs && dec) outst <= outst - 4'd1;
      if (sts_tvalid) begin
        exp_tag <= exp_tag + 4'd1;
        if (sts_good && cnt_en) ok_cnt <= ok_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/dm_chunk_sequencer.sv
// Splits one memory-to-memory copy into CHUNK_BYTES DataMover command pairs,
// tracks both status streams and reports completion or the first error.
module dm_chunk_sequencer
  import dm_pkg::*;
#(
  parameter int CHUNK_BYTES     = 1024,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_src_addr,
  input  logic [31:0] job_dst_addr,
  input  logic [31:0] job_len,
  output logic [71:0] M_AXIS_MM2S_CMD_tdata,
  output logic        M_AXIS_MM2S_CMD_tvalid,
  input  logic        M_AXIS_MM2S_CMD_tready,
  output logic [71:0] M_AXIS_S2MM_CMD_tdata,
  output logic        M_AXIS_S2MM_CMD_tvalid,
  input  logic        M_AXIS_S2MM_CMD_tready,
  input  logic [7:0]  S_AXIS_MM2S_STS_tdata,
  input  logic        S_AXIS_MM2S_STS_tvalid,
  output logic        S_AXIS_MM2S_STS_tready,
  input  logic [7:0]  S_AXIS_S2MM_STS_tdata,
  input  logic        S_AXIS_S2MM_STS_tvalid,
  output logic        S_AXIS_S2MM_STS_tready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  err_status,
  output logic [31:0] chunks_done
);

  localparam int CHUNK_LOG2 = $clog2(CHUNK_BYTES);

  dm_state_t   state;
  logic        accept, run, cnt_en, any_bad;
  logic        mm_all, s2_all, mm_idle, s2_idle, mm_bad, s2_bad;
  logic [31:0] mm_ok, s2_ok, total_w;
  logic [32:0] len_round;
  logic [22:0] rem, last_btt_w;

  assign S_AXIS_MM2S_STS_tready = 1'b1;
  assign S_AXIS_S2MM_STS_tready = 1'b1;

  assign job_ready = (state == ST_IDLE) || (state == ST_DONE);
  assign accept    = job_valid && job_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

  assign len_round  = {1'b0, job_len} + 33'(CHUNK_BYTES - 1);
  assign total_w    = 32'(len_round >> CHUNK_LOG2);
  assign rem        = job_len[22:0] & 23'(CHUNK_BYTES - 1);
  assign last_btt_w = (rem == 23'd0) ? 23'(CHUNK_BYTES) : rem;

  assign any_bad = mm_bad || s2_bad;
  // A bad beat blocks new commands in its own cycle, before err is registered.
  assign run     = (state == ST_ISSUE) && !err && !any_bad;
  assign cnt_en  = !err;

  assign chunks_done = (mm_ok < s2_ok) ? mm_ok : s2_ok;

  dm_cmd_issuer #(.CHUNK_BYTES(CHUNK_BYTES), .MAX_OUTSTANDING(MAX_OUTSTANDING)) u_mm2s (
    .axi_aclk   (axi_aclk),
    .axi_aresetn(axi_aresetn),
    .start      (accept),
    .base       (job_src_addr),
    .total      (total_w),
    .last_btt   (last_btt_w),
    .run        (run),
    .cnt_en     (cnt_en),
    .cmd_tdata  (M_AXIS_MM2S_CMD_tdata),
    .cmd_tvalid (M_AXIS_MM2S_CMD_tvalid),
    .cmd_tready (M_AXIS_MM2S_CMD_tready),
    .sts_tdata  (S_AXIS_MM2S_STS_tdata),
    .sts_tvalid (S_AXIS_MM2S_STS_tvalid),
    .all_issued (mm_all),
    .idle       (mm_idle),
    .sts_bad    (mm_bad),
    .ok_cnt     (mm_ok)
  );

  dm_cmd_issuer #(.CHUNK_BYTES(CHUNK_BYTES), .MAX_OUTSTANDING(MAX_OUTSTANDING)) u_s2mm (
    .axi_aclk   (axi_aclk),
    .axi_aresetn(axi_aresetn),
    .start      (accept),
    .base       (job_dst_addr),
    .total      (total_w),
    .last_btt   (last_btt_w),
    .run        (run),
    .cnt_en     (cnt_en),
    .cmd_tdata  (M_AXIS_S2MM_CMD_tdata),
    .cmd_tvalid (M_AXIS_S2MM_CMD_tvalid),
    .cmd_tready (M_AXIS_S2MM_CMD_tready),
    .sts_tdata  (S_AXIS_S2MM_STS_tdata),
    .sts_tvalid (S_AXIS_S2MM_STS_tvalid),
    .all_issued (s2_all),
    .idle       (s2_idle),
    .sts_bad    (s2_bad),
    .ok_cnt     (s2_ok)
  );

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= ST_IDLE;
      err        <= 1'b0;
      err_status <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) state <= (job_len == 32'd0) ? ST_DONE : ST_ISSUE;
          else        state <= ST_IDLE;
        end
        ST_ISSUE: if (any_bad || err || (mm_all && s2_all)) state <= ST_DRAIN;
        ST_DRAIN: if (mm_idle && s2_idle) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
      // Only the first failing beat of a job is kept; MM2S wins a same-cycle tie.
      if (accept) begin
        err        <= 1'b0;
        err_status <= '0;
      end else if (any_bad && !err && (state == ST_ISSUE || state == ST_DRAIN)) begin
        err        <= 1'b1;
        err_status <= mm_bad ? S_AXIS_MM2S_STS_tdata : S_AXIS_S2MM_STS_tdata;
      end
    end
  end

endmodule
